// File: rtl/maze_render_pkg.sv
// Shared definitions for the maze tile renderer: tile types, colour map,
// engine state encoding and a width helper usable in parameter expressions.
package maze_render_pkg;

   localparam logic [2:0] TILE_PATH  = 3'd0;
   localparam logic [2:0] TILE_WALL  = 3'd1;
   localparam logic [2:0] TILE_START = 3'd2;
   localparam logic [2:0] TILE_GOAL  = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LATCH,
      ST_PIX,
      ST_DONE
   } state_e;

   // Never returns 0 so degenerate sizes still give a legal vector width.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [2:0] tile_colour(input logic [2:0] tile);
      case (tile)
         TILE_PATH:  return 3'b110;
         TILE_WALL:  return 3'b101;
         TILE_START: return 3'b001;
         TILE_GOAL:  return 3'b010;
         default:    return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// Walks the TILE_PX x TILE_PX pixel offsets of one tile, px fastest.
module tile_pixel_counter
   import maze_render_pkg::*;
#(
   parameter  int TILE_PX = 4,
   localparam int PW      = clog2(TILE_PX)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          start,
   input  logic          advance,
   output logic [PW-1:0] px,
   output logic [PW-1:0] py,
   output logic          last
);

   logic [PW-1:0] px_q;
   logic [PW-1:0] py_q;
   logic          px_end;
   logic          py_end;

   assign px_end = (32'(px_q) == TILE_PX - 1);
   assign py_end = (32'(py_q) == TILE_PX - 1);
   assign px     = px_q;
   assign py     = py_q;
   assign last   = px_end && py_end;

   always_ff @(posedge clk) begin
      if (srst || start) begin
         px_q <= '0;
         py_q <= '0;
      end else if (advance) begin
         if (px_end) begin
            px_q <= '0;
            py_q <= py_end ? '0 : py_q + PW'(1);
         end else begin
            px_q <= px_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/maze_tile_renderer.sv
// Arbitrated tile renderer: one full-maze redraw channel plus per-player box
// channels, merged into a single registered VGA pixel stream.
module maze_tile_renderer
   import maze_render_pkg::*;
#(
   parameter  int GRID_W      = 32,
   parameter  int GRID_H      = 32,
   parameter  int TILE_PX     = 4,
   parameter  int NUM_PLAYERS = 2,
   parameter  int CLR_W       = 3,
   parameter  int X_W         = 9,
   parameter  int Y_W         = 9,
   localparam int CW          = clog2(GRID_W),
   localparam int RW          = clog2(GRID_H),
   localparam int ADDR_W      = RW + CW,
   localparam int ID_W        = clog2(NUM_PLAYERS + 1),
   localparam int PTR_W       = clog2(NUM_PLAYERS),
   localparam int PW          = clog2(TILE_PX)
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         maze_req,
   output logic                         maze_ack,
   input  logic [NUM_PLAYERS-1:0]       box_req,
   input  logic [NUM_PLAYERS-1:0]       box_erase,
   input  logic [NUM_PLAYERS*CW-1:0]    box_x,
   input  logic [NUM_PLAYERS*RW-1:0]    box_y,
   input  logic [NUM_PLAYERS*CLR_W-1:0] player_clr,
   output logic [NUM_PLAYERS-1:0]       box_ack,
   output logic                         done,
   output logic [ID_W-1:0]              done_id,
   output logic                         busy,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic [2:0]                   mem_q,
   output logic [X_W-1:0]               vga_x,
   output logic [Y_W-1:0]               vga_y,
   output logic [CLR_W-1:0]             vga_colour,
   output logic                         vga_plot
);

   state_e             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic               job_maze_q;
   logic               job_erase_q;
   logic [CLR_W-1:0]   job_clr_q;
   logic [CW-1:0]      col_q;
   logic [CW-1:0]      col_d;
   logic [RW-1:0]      row_q;
   logic [RW-1:0]      row_d;
   logic [ID_W-1:0]    id_q;
   logic [X_W-1:0]     vga_x_q;
   logic [Y_W-1:0]     vga_y_q;
   logic [CLR_W-1:0]   vga_colour_q;
   logic               vga_plot_q;

   logic               grant_maze;
   logic               grant_box;
   logic [PTR_W-1:0]   grant_idx;
   int                 scan_idx;
   logic               out_of_range;
   logic               last_cell;
   logic [X_W-1:0]     base_x;
   logic [Y_W-1:0]     base_y;
   logic [PW-1:0]      px;
   logic [PW-1:0]      py;
   logic               px_end;
   logic               pix_last;

   // Maze redraw always wins; boxes are scanned round-robin from ptr_q.
   always_comb begin
      grant_maze = 1'b0;
      grant_box  = 1'b0;
      grant_idx  = '0;
      scan_idx   = 0;
      if (!reset && state_q == ST_IDLE) begin
         if (maze_req) begin
            grant_maze = 1'b1;
         end else begin
            for (int k = 0; k < NUM_PLAYERS; k++) begin
               scan_idx = 32'(ptr_q) + k;
               if (scan_idx >= NUM_PLAYERS) scan_idx = scan_idx - NUM_PLAYERS;
               if (!grant_box && box_req[scan_idx]) begin
                  grant_box = 1'b1;
                  grant_idx = PTR_W'(scan_idx);
               end
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_ack
      assign box_ack[gi] = grant_box && (32'(grant_idx) == gi);
   end

   assign ptr_d = (32'(grant_idx) == NUM_PLAYERS - 1) ? '0 : grant_idx + PTR_W'(1);

   always_comb begin
      col_d = col_q + CW'(1);
      row_d = row_q;
      if (32'(col_q) == GRID_W - 1) begin
         col_d = '0;
         row_d = row_q + RW'(1);
      end
   end

   assign last_cell    = (32'(col_q) == GRID_W - 1) && (32'(row_q) == GRID_H - 1);
   assign out_of_range = (32'(col_q) >= GRID_W) || (32'(row_q) >= GRID_H);
   assign base_x       = X_W'(32'(col_q) * 32'(TILE_PX));
   assign base_y       = Y_W'(32'(row_q) * 32'(TILE_PX));
   assign px_end       = (32'(px) == TILE_PX - 1);

   tile_pixel_counter #(
      .TILE_PX (TILE_PX)
   ) u_pix (
      .clk     (CLOCK_50),
      .srst    (reset),
      .start   (state_q == ST_LATCH),
      .advance (state_q == ST_PIX && !pix_last),
      .px      (px),
      .py      (py),
      .last    (pix_last)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         job_maze_q   <= 1'b0;
         job_erase_q  <= 1'b0;
         job_clr_q    <= '0;
         col_q        <= '0;
         row_q        <= '0;
         id_q         <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_maze) begin
                  state_q     <= ST_ADDR;
                  job_maze_q  <= 1'b1;
                  job_erase_q <= 1'b0;
                  job_clr_q   <= '0;
                  col_q       <= '0;
                  row_q       <= '0;
                  id_q        <= '0;
               end else if (grant_box) begin
                  state_q     <= ST_ADDR;
                  job_maze_q  <= 1'b0;
                  job_erase_q <= box_erase[grant_idx];
                  job_clr_q   <= player_clr[32'(grant_idx)*CLR_W +: CLR_W];
                  col_q       <= box_x[32'(grant_idx)*CW +: CW];
                  row_q       <= box_y[32'(grant_idx)*RW +: RW];
                  id_q        <= ID_W'(32'(grant_idx) + 1);
                  ptr_q       <= ptr_d;
               end
            end
            ST_ADDR: begin
               state_q <= (!job_maze_q && out_of_range) ? ST_DONE : ST_LATCH;
            end
            ST_LATCH: begin
               // mem_q now holds the tile addressed during ST_ADDR.
               vga_x_q      <= base_x;
               vga_y_q      <= base_y;
               vga_colour_q <= (job_maze_q || job_erase_q) ? CLR_W'(tile_colour(mem_q)) : job_clr_q;
               vga_plot_q   <= 1'b1;
               state_q      <= ST_PIX;
            end
            ST_PIX: begin
               if (!pix_last) begin
                  if (px_end) begin
                     vga_x_q <= base_x;
                     vga_y_q <= base_y + Y_W'(py) + Y_W'(1);
                  end else begin
                     vga_x_q <= base_x + X_W'(px) + X_W'(1);
                  end
               end else begin
                  vga_plot_q <= 1'b0;
                  if (job_maze_q && !last_cell) begin
                     col_q   <= col_d;
                     row_q   <= row_d;
                     state_q <= ST_ADDR;
                  end else begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign maze_ack   = grant_maze;
   assign busy       = (state_q != ST_IDLE) || grant_maze || grant_box;
   assign done       = (state_q == ST_DONE);
   assign done_id    = done ? id_q : '0;
   assign mem_addr   = {row_q, col_q};
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Randomised requesters against a job-level reference model; expected plots,
// done pulses and grants are queued at ack and matched by a negedge monitor.
module tb_maze_tile_renderer;

   localparam int GW = 10, GH = 9, T = 2, NP = 3, CLR_W = 3, XW = 9, YW = 9;
   localparam int CW = 4, RW = 4, AW = 8, IDW = 2;
   localparam int CELL_CYC = T * T + 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              maze_req;
   logic              maze_ack;
   logic [NP-1:0]     box_req, box_erase, box_ack;
   logic [NP*CW-1:0]  box_x;
   logic [NP*RW-1:0]  box_y;
   logic [NP*CLR_W-1:0] player_clr;
   logic              done;
   logic [IDW-1:0]    done_id;
   logic              busy;
   logic [AW-1:0]     mem_addr;
   logic [2:0]        mem_q;
   logic [XW-1:0]     vga_x;
   logic [YW-1:0]     vga_y;
   logic [CLR_W-1:0]  vga_colour;
   logic              vga_plot;

   logic              req_b   [NP];
   logic              erase_b [NP];
   logic [CW-1:0]     x_b     [NP];
   logic [RW-1:0]     y_b     [NP];
   logic [CLR_W-1:0]  clr_b   [NP];

   typedef struct {int x; int y; int c; int cyc;} plot_t;
   plot_t      plotq[$];
   logic [2:0] ram [0:(1<<AW)-1];
   int         cmap [8] = '{6, 5, 1, 2, 0, 0, 0, 0};
   int         cyc = 0, checks = 0, errors = 0;
   int         exp_done_cyc = 0, exp_id = 0, rr = 0;
   bit         busy_m = 0, rst_prev = 0, stop = 0;
   bit         ack_seen [NP];
   bit         maze_ack_seen = 0;

   always #5 clk = ~clk;

   maze_tile_renderer #(
      .GRID_W(GW), .GRID_H(GH), .TILE_PX(T), .NUM_PLAYERS(NP),
      .CLR_W(CLR_W), .X_W(XW), .Y_W(YW)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .maze_req(maze_req), .maze_ack(maze_ack),
      .box_req(box_req), .box_erase(box_erase), .box_x(box_x), .box_y(box_y),
      .player_clr(player_clr), .box_ack(box_ack), .done(done), .done_id(done_id),
      .busy(busy), .mem_addr(mem_addr), .mem_q(mem_q), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always @(posedge clk) mem_q <= ram[mem_addr];

   always_comb begin
      box_req = '0; box_erase = '0; box_x = '0; box_y = '0; player_clr = '0;
      for (int i = 0; i < NP; i++) begin
         box_req[i]                 = req_b[i];
         box_erase[i]               = erase_b[i];
         box_x[i*CW +: CW]          = x_b[i];
         box_y[i*RW +: RW]          = y_b[i];
         player_clr[i*CLR_W +: CLR_W] = clr_b[i];
      end
   end

   // Reference: every pixel of the job with the cycle it must appear on.
   function automatic void start_job(bit is_maze, int ch);
      int clr, bx, by;
      busy_m = 1;
      if (is_maze) begin
         exp_id = 0;
         exp_done_cyc = cyc + GW * GH * CELL_CYC + 1;
         for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++) begin
               clr = cmap[ram[r * (1 << CW) + c]];
               for (int py = 0; py < T; py++)
                  for (int px = 0; px < T; px++)
                     plotq.push_back('{x: c*T+px, y: r*T+py, c: clr,
                        cyc: cyc + (r*GW+c)*CELL_CYC + 3 + py*T + px});
            end
         $display("ack maze cyc=%0d", cyc);
      end else begin
         bx = int'(x_b[ch]); by = int'(y_b[ch]);
         exp_id = ch + 1;
         rr = (ch + 1) % NP;
         if (bx >= GW || by >= GH) begin
            exp_done_cyc = cyc + 2;
         end else begin
            clr = erase_b[ch] ? cmap[ram[by * (1 << CW) + bx]] : int'(clr_b[ch]);
            for (int py = 0; py < T; py++)
               for (int px = 0; px < T; px++)
                  plotq.push_back('{x: bx*T+px, y: by*T+py, c: clr, cyc: cyc + 3 + py*T + px});
            exp_done_cyc = cyc + CELL_CYC + 1;
         end
         $display("ack box ch=%0d cell=(%0d,%0d) erase=%0d cyc=%0d", ch, bx, by, erase_b[ch], cyc);
      end
   endfunction

   always @(negedge clk) begin
      bit busy_before, exp_maze;
      int exp_box;
      logic [NP-1:0] exp_vec;
      plot_t p;
      cyc++;
      if (reset) begin
         checks++;
         if (maze_ack || box_ack != '0) begin
            errors++;
            $display("FAIL ack_in_reset cyc=%0d got maze_ack=%0d box_ack=%b want 0", cyc, maze_ack, box_ack);
         end
         if (rst_prev) begin
            checks++;
            if (maze_ack || box_ack != '0 || done || done_id != '0 || busy || mem_addr != '0 ||
                vga_x != '0 || vga_y != '0 || vga_colour != '0 || vga_plot) begin
               errors++;
               $display("FAIL reset_outputs cyc=%0d got done=%0d busy=%0d plot=%0d x=%0d y=%0d clr=%0d addr=%0d want all 0",
                        cyc, done, busy, vga_plot, vga_x, vga_y, vga_colour, mem_addr);
            end
         end
         plotq.delete(); busy_m = 0; rr = 0; rst_prev = 1; maze_ack_seen = 0;
         for (int i = 0; i < NP; i++) ack_seen[i] = 0;
      end else begin
         rst_prev = 0;
         busy_before = busy_m;
         checks++;
         if (busy_m && (done || cyc == exp_done_cyc)) begin
            if (!done || cyc != exp_done_cyc || int'(done_id) != exp_id) begin
               errors++;
               $display("FAIL done cyc=%0d got done=%0d id=%0d want cyc=%0d id=%0d",
                        cyc, done, done_id, exp_done_cyc, exp_id);
            end
            checks++;
            if (plotq.size() != 0) begin
               errors++;
               $display("FAIL missing_plots cyc=%0d got %0d unplotted want 0", cyc, plotq.size());
            end
            $display("done id=%0d cyc=%0d", done_id, cyc);
            plotq.delete();
            busy_m = 0;
         end else if (done) begin
            errors++;
            $display("FAIL spurious_done cyc=%0d got done=1 id=%0d want 0", cyc, done_id);
         end
         if (vga_plot) begin
            checks++;
            if (plotq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_plot cyc=%0d got x=%0d y=%0d want no plot", cyc, vga_x, vga_y);
            end else begin
               p = plotq.pop_front();
               if (int'(vga_x) != p.x || int'(vga_y) != p.y || int'(vga_colour) != p.c || cyc != p.cyc) begin
                  errors++;
                  $display("FAIL plot got x=%0d y=%0d c=%0d cyc=%0d want x=%0d y=%0d c=%0d cyc=%0d",
                           vga_x, vga_y, vga_colour, cyc, p.x, p.y, p.c, p.cyc);
               end
            end
         end
         exp_maze = 0; exp_box = -1; exp_vec = '0;
         if (!busy_before) begin
            if (maze_req) exp_maze = 1;
            else for (int k = 0; k < NP; k++)
               if (exp_box < 0 && req_b[(rr + k) % NP]) exp_box = (rr + k) % NP;
         end
         if (exp_box >= 0) exp_vec[exp_box] = 1'b1;
         checks++;
         if (maze_ack !== exp_maze || box_ack !== exp_vec) begin
            errors++;
            $display("FAIL grant cyc=%0d got maze_ack=%0d box_ack=%b want maze_ack=%0d box_ack=%b",
                     cyc, maze_ack, box_ack, exp_maze, exp_vec);
         end
         checks++;
         if (busy !== (busy_before || exp_maze || exp_box >= 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %0d want %0d", cyc, busy, busy_before || exp_maze || exp_box >= 0);
         end
         if (exp_maze || exp_box >= 0) start_job(exp_maze, exp_box);
         maze_ack_seen = maze_ack;
         for (int i = 0; i < NP; i++) ack_seen[i] = box_ack[i];
      end
   end

   for (genvar gi = 0; gi < NP; gi++) begin : g_box
      initial begin
         int waited;
         waited = 0;
         req_b[gi] = 1'b1; erase_b[gi] = 1'b0;
         x_b[gi] = CW'(gi + 5); y_b[gi] = RW'(gi + 2); clr_b[gi] = CLR_W'(gi + 1);
         forever begin
            @(posedge clk); #1;
            if (req_b[gi]) begin
               if (ack_seen[gi]) begin
                  req_b[gi] = 1'b0; waited = 0;
               end else begin
                  waited++;
                  if (waited > 60 && $urandom % 8 == 0) begin req_b[gi] = 1'b0; waited = 0; end
               end
            end else if (!stop && $urandom % 12 == 0) begin
               x_b[gi]     = ($urandom % 5 == 0) ? CW'($urandom) : CW'($urandom % GW);
               y_b[gi]     = ($urandom % 5 == 0) ? RW'($urandom) : RW'($urandom % GH);
               erase_b[gi] = 1'($urandom);
               clr_b[gi]   = CLR_W'($urandom);
               req_b[gi]   = 1'b1;
               waited      = 0;
            end
         end
      end
   end

   initial begin
      maze_req = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (maze_req) begin
            if (maze_ack_seen) maze_req = 1'b0;
         end else if (!stop && $urandom % 700 == 0) begin
            maze_req = 1'b1;
         end
      end
   end

   initial begin
      int w;
      bit idle;
      for (int a = 0; a < (1 << AW); a++) ram[a] = 3'($urandom);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3000) @(posedge clk);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(vga_plot && plotq.size() > 2) && w < 3000);
      checks++;
      if (!(vga_plot && plotq.size() > 2)) begin
         errors++;
         $display("FAIL reset_window got no mid-tile plot within %0d cycles want one", w);
      end
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3000) @(posedge clk);
      stop = 1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
         idle = !busy_m && !maze_req;
         for (int i = 0; i < NP; i++) if (req_b[i]) idle = 0;
      end while (!idle && w < 4000);
      checks++;
      if (!idle || plotq.size() != 0) begin
         errors++;
         $display("FAIL drain got busy_m=%0d pending=%0d want idle and 0", busy_m, plotq.size());
      end
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
